// File: rtl/mojo_arith_pkg.sv
// Shared arithmetic definitions for the lock-loop multiplier and divider.
// Holds the FSM state type, shift pass-through codes and datapath widths.
package mojo_arith_pkg;

    localparam int OPW  = 16;
    localparam int RESW = 32;

    localparam logic [3:0] SHIFT_PASS_IN0 = 4'h0;
    localparam logic [3:0] SHIFT_PASS_IN1 = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        FIX,
        SCALE
    } state_t;

endpackage

// File: rtl/multiplier.sv
// Sequential signed x unsigned 16x16 shift-add multiplier with arithmetic right-shift.
// Optional MULTIPLIER_ROUND_EN rounds the final shift half toward +inf.
module multiplier
    import mojo_arith_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            once,
    output logic            done,
    input  logic [OPW-1:0]  in0,
    input  logic [OPW-1:0]  in1,
    input  logic [3:0]      shift,
    output logic [RESW-1:0] out
);

    state_t           r_state;
    state_t           w_next;
    logic             r_sign;
    logic [OPW-1:0]   r_mag;
    logic [OPW-1:0]   r_mplr;
    logic [3:0]       r_shift;
    logic [3:0]       r_cnt;
    logic [RESW-1:0]  r_acc;
    logic [RESW-1:0]  r_out;
    logic             r_done;
    logic             w_bypass;
    logic [OPW-1:0]   w_mag;
    logic [RESW-1:0]  w_addend;
    logic [RESW-1:0]  w_scaled;

    assign w_bypass = (shift == SHIFT_PASS_IN0) || (shift == SHIFT_PASS_IN1);
    assign w_mag    = in0[OPW-1] ? (~in0 + 16'd1) : in0;
    assign w_addend = r_mplr[r_cnt] ? ({16'h0, r_mag} << r_cnt) : 32'h0;

`ifdef MULTIPLIER_ROUND_EN
    // 33-bit sum keeps the rounding bias from wrapping the accumulator
    logic signed [RESW:0] w_half;
    assign w_half   = 33'sd1 << (r_shift - 4'd1);
    assign w_scaled = 32'(($signed({r_acc[RESW-1], r_acc}) + w_half) >>> r_shift);
`else
    assign w_scaled = 32'($signed(r_acc) >>> r_shift);
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (once && !w_bypass) w_next = MUL;
            MUL:     if (r_cnt == 4'd15) w_next = FIX;
            FIX:     w_next = SCALE;
            SCALE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign  <= 1'b0;
            r_mag   <= '0;
            r_mplr  <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (once) begin
                        if (shift == SHIFT_PASS_IN0) begin
                            r_out  <= {16'h0, in0};
                            r_done <= 1'b1;
                        end else if (shift == SHIFT_PASS_IN1) begin
                            r_out  <= {16'h0, in1};
                            r_done <= 1'b1;
                        end else begin
                            r_sign  <= in0[OPW-1];
                            r_mag   <= w_mag;
                            r_mplr  <= in1;
                            r_shift <= shift;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                        end
                    end
                end
                MUL: begin
                    r_acc <= r_acc + w_addend;
                    r_cnt <= r_cnt + 4'd1;
                end
                FIX: begin
                    if (r_sign) r_acc <= 32'd0 - r_acc;
                end
                SCALE: begin
                    r_out  <= w_scaled;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out  = r_out;
    assign done = r_done;

endmodule

// File: tb/tb_multiplier.sv
// Randomised bench for multiplier against an integer-arithmetic reference.
// Covers bypass codes, latency, ignored restarts and mid-operation reset.
module tb_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        once;
    logic        done;
    logic [15:0] in0;
    logic [15:0] in1;
    logic [3:0]  shift;
    logic [31:0] out;

    int n_tests = 0;
    int n_fail  = 0;

    multiplier dut (
        .clk   (clk),
        .rst   (rst),
        .once  (once),
        .done  (done),
        .in0   (in0),
        .in1   (in1),
        .shift (shift),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [3:0] s);
        longint p, d, q;
        if (s == 4'h0) return {16'h0, a};
        if (s == 4'hF) return {16'h0, b};
        p = longint'($signed(a)) * longint'({48'h0, b});
        d = 64'sd1 << s;
`ifdef MULTIPLIER_ROUND_EN
        p = p + d / 2;
`endif
        q = p / d;
        if ((p % d != 0) && (p < 0)) q = q - 1;
        return q[31:0];
    endfunction

    task automatic run(input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] s, input bit glitch,
                       output logic [31:0] res, output int lat);
        @(negedge clk);
        in0 = a; in1 = b; shift = s; once = 1'b1;
        @(posedge clk); #1;
        once = 1'b0;
        in0 = 16'($urandom); in1 = 16'($urandom); shift = 4'($urandom);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            once = (glitch && (k == 3 || k == 10));
            @(posedge clk); #1;
        end
        once = 1'b0;
        res = out;
    endtask

    task automatic op(input string tag, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] s,
                      input bit glitch, input logic [31:0] exp);
        logic [31:0] res;
        int lat;
        bit byp;
        byp = (s == 4'h0) || (s == 4'hF);
        run(a, b, s, glitch, res, lat);
        if (lat < 0) begin
            check({tag, "_timeout"}, 32'(lat), byp ? 32'd0 : 32'd18);
        end else begin
            check(tag, res, exp);
            check({tag, "_lat"}, 32'(lat), byp ? 32'd0 : 32'd18);
            @(posedge clk); #1;
            check({tag, "_pulse"}, {31'h0, done}, 32'h0);
            check({tag, "_hold"}, out, res);
        end
    endtask

    initial begin
        logic [15:0] a, b;
        logic [3:0]  s;
        int pulses;
        rst = 1'b1; once = 1'b0; in0 = '0; in1 = '0; shift = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", out, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        @(negedge clk); rst = 1'b0;

`ifdef MULTIPLIER_ROUND_EN
        op("neg3x5", 16'hFFFD, 16'd5, 4'd1, 1'b0, 32'hFFFFFFF9);
`else
        op("neg3x5", 16'hFFFD, 16'd5, 4'd1, 1'b0, 32'hFFFFFFF8);
`endif
        op("maxpos", 16'h7FFF, 16'hFFFF, 4'd14, 1'b0, 32'h0001FFFA);
        op("minneg", 16'h8000, 16'hFFFF, 4'd1, 1'b0, 32'hC0004000);
        op("pass0", 16'h8001, 16'hBEEF, 4'h0, 1'b0, 32'h00008001);
        op("pass15", 16'hBEEF, 16'h1234, 4'hF, 1'b0, 32'h00001234);
        op("glitch", 16'hF123, 16'h4567, 4'd5, 1'b1,
           model(16'hF123, 16'h4567, 4'd5));

        // abort during the multiply and make sure nothing leaks out
        @(negedge clk);
        in0 = 16'h1234; in1 = 16'h5678; shift = 4'd3; once = 1'b1;
        @(posedge clk); #1;
        once = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out", out, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort_stray", 32'(pulses), 32'd0);
        op("after_abort", 16'hFF00, 16'h00FF, 4'd2, 1'b0,
           model(16'hFF00, 16'h00FF, 4'd2));

        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = (i % 8 == 0) ? 4'h0 : (i % 8 == 4) ? 4'hF
                             : 4'($urandom_range(1, 14));
            op("rand", a, b, s, 1'b0, model(a, b, s));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
